// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte-enabled synchronous RAM behind the MEM-stage LSU.
// Each request takes two cycles, an accept cycle that stalls and a RESP cycle that pulses done.
module dmem_ctrl #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_web,
    input  logic [31:0] req_dib,
    output logic        stall,
    output logic        done,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        fault_valid,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_addr
);

    typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

    state_t                  r_state, w_next;
    logic [31:0]             r_mem [0:(2**ADDR_WIDTH)-1];
    logic                    r_fault, r_is_load;
    logic [31:0]             r_rdata, r_fault_addr;
    logic [1:0]              r_fault_cause;

    logic                    w_accept, w_misal, w_illegal, w_oor, w_fault;
    logic [ADDR_WIDTH-1:0]   w_widx;
    logic [31:0]             w_wdata;

    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_widx   = req_addr[ADDR_WIDTH+1:2];
    assign w_wdata  = req_dib << {req_addr[1:0], 3'b000};
    assign w_oor    = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
    assign w_fault  = w_misal || w_illegal || w_oor;

    always_comb begin
        w_misal   = 1'b0;
        w_illegal = 1'b0;
        case (req_funct3)
            3'b000:  ;
            3'b001:  w_misal = req_addr[0];
            3'b010:  w_misal = req_addr[1:0] != 2'b00;
            3'b100:  w_illegal = req_write;
            3'b101:  begin
                w_misal   = req_addr[0];
                w_illegal = req_write;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // RAM has no reset; a reset on the accept edge must still block the write.
    always_ff @(posedge clk) begin
        if (!rst && w_accept && req_write && !w_fault) begin
            for (int i = 0; i < 4; i++)
                if (req_web[i]) r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault       <= 1'b0;
            r_is_load     <= 1'b0;
            r_rdata       <= 32'd0;
            r_fault_addr  <= 32'd0;
            r_fault_cause <= 2'b00;
        end else if (w_accept) begin
            r_fault   <= w_fault;
            r_is_load <= !req_write;
            if (!req_write) r_rdata <= w_fault ? 32'd0 : r_mem[w_widx];
            if (w_fault) begin
                r_fault_addr  <= req_addr;
                r_fault_cause <= {!w_misal, req_write};
            end
        end
    end

    always_comb begin
        stall       = (r_state == S_IDLE) && req_valid;
        done        = (r_state == S_RESP);
        rdata_valid = (r_state == S_RESP) && r_is_load && !r_fault;
        fault_valid = (r_state == S_RESP) && r_fault;
    end

    assign rdata       = r_rdata;
    assign fault_addr  = r_fault_addr;
    assign fault_cause = r_fault_cause;

endmodule
